// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Pipeline sequencing controller for the 5-stage core.
//                Detects load-use hazards, flushes on taken branches and
//                sequences precise exceptions, external interrupts and
//                exception return through a small state machine with a
//                configurable drain counter.
//                Optional feature macro: PIPE_CTRL_IRQ_EN (interrupt path,
//                IRQ mask and irq_ack present when defined).
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_ex_mem_read,
    input  logic [4:0] id_ex_rt,
    input  logic [4:0] if_id_rs,
    input  logic [4:0] if_id_rt,
    input  logic       branch_taken,
    input  logic       exc_valid,
    input  logic [4:0] exc_code,
    input  logic       irq_req,
    input  logic [4:0] irq_vector,
    input  logic       eret,
    output logic       pc_write,
    output logic [1:0] pc_sel,
    output logic       if_id_write,
    output logic       if_flush,
    output logic       id_flush,
    output logic       ex_flush,
    output logic       epc_write,
    output logic [4:0] vector_out,
    output logic       irq_ack,
    output logic       exc_busy
);

    localparam logic [2:0] c_state_run     = 3'd0;
    localparam logic [2:0] c_state_flush   = 3'd1;
    localparam logic [2:0] c_state_vector  = 3'd2;
    localparam logic [2:0] c_state_handler = 3'd3;
    localparam logic [2:0] c_state_return  = 3'd4;

    localparam logic [1:0] c_pc_plus4  = 2'b00;
    localparam logic [1:0] c_pc_branch = 2'b01;
    localparam logic [1:0] c_pc_vector = 2'b10;
    localparam logic [1:0] c_pc_epc    = 2'b11;

    localparam logic [4:0] c_double_fault = 5'h1F;

    logic [2:0] r_state;
    logic [2:0] w_state_next;
    logic [3:0] r_drain_cnt;
    logic [4:0] r_vector;
    logic       w_in_run;
    logic       w_in_handler;
    logic       w_stall;
    logic       w_exc_take;
    logic       w_irq_take;
    logic [4:0] w_irq_code;

    assign w_in_run     = (r_state == c_state_run);
    assign w_in_handler = (r_state == c_state_handler);

    // A load in EX writing a register that ID reads; r0 never creates a hazard.
    assign w_stall = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                     ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

    assign w_exc_take = exc_valid && (w_in_run || w_in_handler);

`ifdef PIPE_CTRL_IRQ_EN
    logic r_irq_mask;
    logic r_irq_ack;

    // Interrupts are only taken from RUN with the mask clear.
    assign w_irq_take = irq_req && w_in_run && !r_irq_mask;
    assign w_irq_code = irq_vector;
    assign irq_ack    = r_irq_ack;

    // Mask is raised on vector entry and dropped on exception return.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq_mask <= 1'b0;
        end else if (r_state == c_state_vector) begin
            r_irq_mask <= 1'b1;
        end else if (r_state == c_state_return) begin
            r_irq_mask <= 1'b0;
        end
    end

    // One-cycle acknowledge, only when the interrupt wins over an exception.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq_ack <= 1'b0;
        end else begin
            r_irq_ack <= w_irq_take && !w_exc_take;
        end
    end
`else
    logic w_unused_irq;

    assign w_irq_take   = 1'b0;
    assign w_irq_code   = 5'd0;
    assign irq_ack      = 1'b0;
    assign w_unused_irq = &{1'b0, irq_req, irq_vector};
`endif

    assign vector_out = r_vector;
    assign exc_busy   = !(w_in_run || w_in_handler);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_state_run;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state selection.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_state_run: begin
                if (w_exc_take || w_irq_take) begin
                    w_state_next = c_state_flush;
                end
            end
            c_state_handler: begin
                if (w_exc_take) begin
                    w_state_next = c_state_flush;
                end else if (eret && !w_stall) begin
                    w_state_next = c_state_return;
                end
            end
            c_state_flush: begin
                if (r_drain_cnt <= 4'd1) begin
                    w_state_next = c_state_vector;
                end
            end
            c_state_vector:  w_state_next = c_state_handler;
            c_state_return:  w_state_next = c_state_run;
            default:         w_state_next = c_state_run;
        endcase
    end

    // Drain counter and cause-code capture on event acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drain_cnt <= 4'd0;
            r_vector    <= 5'd0;
        end else if (w_exc_take) begin
            r_drain_cnt <= 4'(DRAIN_CYCLES);
            r_vector    <= w_in_run ? exc_code : c_double_fault;
        end else if (w_irq_take) begin
            r_drain_cnt <= 4'(DRAIN_CYCLES);
            r_vector    <= w_irq_code;
        end else if ((r_state == c_state_flush) && (r_drain_cnt != 4'd0)) begin
            r_drain_cnt <= r_drain_cnt - 4'd1;
        end
    end

    // Pipeline control outputs per state and same-cycle event priority.
    always_comb begin
        pc_write    = 1'b1;
        pc_sel      = c_pc_plus4;
        if_id_write = 1'b1;
        if_flush    = 1'b0;
        id_flush    = 1'b0;
        ex_flush    = 1'b0;
        epc_write   = 1'b0;
        case (r_state)
            c_state_flush: begin
                pc_write = 1'b0;
                if_flush = 1'b1;
                id_flush = 1'b1;
                ex_flush = 1'b1;
            end
            c_state_vector: begin
                pc_sel   = c_pc_vector;
                if_flush = 1'b1;
            end
            c_state_return: begin
                pc_sel   = c_pc_epc;
                if_flush = 1'b1;
            end
            default: begin
                if (w_exc_take || w_irq_take) begin
                    pc_write  = 1'b0;
                    if_flush  = 1'b1;
                    id_flush  = 1'b1;
                    ex_flush  = 1'b1;
                    epc_write = w_in_run;
                end else if (w_stall) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_flush    = 1'b1;
                end else if (branch_taken) begin
                    pc_sel   = c_pc_branch;
                    if_flush = 1'b1;
                end
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Self-checking bench for pipe_hazard_ctrl. A timeline model
//                predicts every output each cycle; directed literal checks
//                pin the model. Honours PIPE_CTRL_IRQ_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int c_DRAIN = 2;
`ifdef PIPE_CTRL_IRQ_EN
    localparam bit c_IRQ_EN = 1'b1;
`else
    localparam bit c_IRQ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       id_ex_mem_read;
    logic [4:0] id_ex_rt;
    logic [4:0] if_id_rs;
    logic [4:0] if_id_rt;
    logic       branch_taken;
    logic       exc_valid;
    logic [4:0] exc_code;
    logic       irq_req;
    logic [4:0] irq_vector;
    logic       eret;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic       if_id_write;
    logic       if_flush;
    logic       id_flush;
    logic       ex_flush;
    logic       epc_write;
    logic [4:0] vector_out;
    logic       irq_ack;
    logic       exc_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model state: cycle of last accepted event, cycle of RETURN, ack cycle.
    int         m_acc = -100;
    int         m_ret = -1;
    int         m_ack = -1;
    bit         m_hdl = 1'b0;
    logic [4:0] m_vec = 5'd0;

    pipe_hazard_ctrl #(.DRAIN_CYCLES(c_DRAIN)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rt       (id_ex_rt),
        .if_id_rs       (if_id_rs),
        .if_id_rt       (if_id_rt),
        .branch_taken   (branch_taken),
        .exc_valid      (exc_valid),
        .exc_code       (exc_code),
        .irq_req        (irq_req),
        .irq_vector     (irq_vector),
        .eret           (eret),
        .pc_write       (pc_write),
        .pc_sel         (pc_sel),
        .if_id_write    (if_id_write),
        .if_flush       (if_flush),
        .id_flush       (id_flush),
        .ex_flush       (ex_flush),
        .epc_write      (epc_write),
        .vector_out     (vector_out),
        .irq_ack        (irq_ack),
        .exc_busy       (exc_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_ex_mem_read = 1'b0;
        id_ex_rt       = 5'd0;
        if_id_rs       = 5'd0;
        if_id_rt       = 5'd0;
        branch_taken   = 1'b0;
        exc_valid      = 1'b0;
        exc_code       = 5'd0;
        irq_req        = 1'b0;
        irq_vector     = 5'd0;
        eret           = 1'b0;
    endtask

    // Called in the first drain cycle after an accepted event: run through
    // drain and vector into the handler, then eret back to RUN.
    task automatic finish_event();
        repeat (c_DRAIN + 1) tick();
        eret = 1'b1;
        tick();
        eret = 1'b0;
        tick();
    endtask

    // Per-cycle model compare.
    always @(negedge clk) begin : p_compare
        bit ph_flush;
        bit ph_vec;
        bit ph_ret;
        bit ph_busy;
        bit ev_exc;
        bit ev_irq;
        bit hz;
        bit e_pw;
        bit e_ifw;
        bit e_iff;
        bit e_idf;
        bit e_exf;
        bit e_epc;
        int e_sel;
        if (!reset) begin
            m_acc = -100;
            m_ret = -1;
            m_ack = -1;
            m_hdl = 1'b0;
            m_vec = 5'd0;
        end
        ph_flush = (cyc - m_acc >= 1) && (cyc - m_acc <= c_DRAIN);
        ph_vec   = (cyc - m_acc == c_DRAIN + 1);
        ph_ret   = (cyc == m_ret);
        ph_busy  = ph_flush || ph_vec || ph_ret;
        hz = id_ex_mem_read && (id_ex_rt != 0) &&
             ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
        ev_exc = 1'b0;
        ev_irq = 1'b0;
        e_pw = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_exf = 0; e_epc = 0; e_sel = 0;
        if (ph_flush) begin
            e_pw = 0; e_iff = 1; e_idf = 1; e_exf = 1;
        end else if (ph_vec) begin
            e_sel = 2; e_iff = 1;
        end else if (ph_ret) begin
            e_sel = 3; e_iff = 1;
        end else begin
            ev_exc = exc_valid;
            ev_irq = c_IRQ_EN && irq_req && !m_hdl;
            if (ev_exc || ev_irq) begin
                e_pw = 0; e_iff = 1; e_idf = 1; e_exf = 1; e_epc = !m_hdl;
            end else if (hz) begin
                e_pw = 0; e_ifw = 0; e_idf = 1;
            end else if (branch_taken) begin
                e_sel = 1; e_iff = 1;
            end
        end
        chk("m_pc_write",    pc_write,    e_pw);
        chk("m_pc_sel",      pc_sel,      e_sel);
        chk("m_if_id_write", if_id_write, e_ifw);
        chk("m_if_flush",    if_flush,    e_iff);
        chk("m_id_flush",    id_flush,    e_idf);
        chk("m_ex_flush",    ex_flush,    e_exf);
        chk("m_epc_write",   epc_write,   e_epc);
        chk("m_vector_out",  vector_out,  m_vec);
        chk("m_irq_ack",     irq_ack,     (cyc == m_ack) ? 1 : 0);
        chk("m_exc_busy",    exc_busy,    ph_busy);
        if (reset) begin
            if (ev_exc || ev_irq) begin
                m_acc = cyc;
                if (ev_exc) begin
                    m_vec = m_hdl ? 5'h1F : exc_code;
                end else begin
                    m_vec = irq_vector;
                    m_ack = cyc + 1;
                end
            end else if (!ph_busy && m_hdl && eret && !hz) begin
                m_ret = cyc + 1;
            end
            if (ph_vec) m_hdl = 1'b1;
            if (ph_ret) m_hdl = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        idle();
        tick();
        tick();
        @(negedge clk);
        chk("rst_vector", vector_out, 0);
        chk("rst_ack", irq_ack, 0);
        chk("rst_busy", exc_busy, 0);
        chk("rst_pc_write", pc_write, 1);
        tick();
        reset = 1'b1;
        tick();

        // Load-use hazards
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd5; if_id_rs = 5'd5;
        @(negedge clk);
        chk("lu_pc_write", pc_write, 0);
        chk("lu_if_id_write", if_id_write, 0);
        chk("lu_id_flush", id_flush, 1);
        tick();
        id_ex_rt = 5'd0;
        @(negedge clk);
        chk("lu_r0_pc_write", pc_write, 1);
        chk("lu_r0_id_flush", id_flush, 0);
        tick();
        id_ex_rt = 5'd7; if_id_rs = 5'd1; if_id_rt = 5'd7;
        @(negedge clk);
        chk("lu_rt_if_id_write", if_id_write, 0);
        tick();

        // Stall masks a same-cycle branch; branch acts once the stall clears
        id_ex_rt = 5'd5; if_id_rs = 5'd5; if_id_rt = 5'd0; branch_taken = 1'b1;
        @(negedge clk);
        chk("sb_pc_sel", pc_sel, 0);
        chk("sb_if_flush", if_flush, 0);
        tick();
        id_ex_mem_read = 1'b0;
        @(negedge clk);
        chk("br_pc_sel", pc_sel, 1);
        chk("br_if_flush", if_flush, 1);
        tick();
        idle();

        // Exception in RUN, code held into the drain must be ignored
        exc_valid = 1'b1; exc_code = 5'h0C;
        @(negedge clk);
        chk("ex_epc_write", epc_write, 1);
        chk("ex_pc_write", pc_write, 0);
        chk("ex_ex_flush", ex_flush, 1);
        tick();
        exc_code = 5'h07;
        @(negedge clk);
        chk("ex_vector", vector_out, 5'h0C);
        chk("ex_busy1", exc_busy, 1);
        chk("ex_flush1", ex_flush, 1);
        tick();
        exc_valid = 1'b0;
        @(negedge clk);
        chk("ex_busy2", exc_busy, 1);
        chk("ex_pc_write2", pc_write, 0);
        tick();
        @(negedge clk);
        chk("ex_sel_vec", pc_sel, 2);
        chk("ex_pcw_vec", pc_write, 1);
        tick();
        @(negedge clk);
        chk("ex_busy_done", exc_busy, 0);
        chk("ex_vector_hold", vector_out, 5'h0C);

        // Branch still works in HANDLER
        branch_taken = 1'b1;
        @(negedge clk);
        chk("hd_branch_sel", pc_sel, 1);
        tick();
        branch_taken = 1'b0;

        // Double fault
        exc_valid = 1'b1; exc_code = 5'h05;
        @(negedge clk);
        chk("df_epc_write", epc_write, 0);
        chk("df_if_flush", if_flush, 1);
        tick();
        exc_valid = 1'b0;
        @(negedge clk);
        chk("df_vector", vector_out, 5'h1F);
        repeat (c_DRAIN + 1) tick();
        @(negedge clk);
        chk("df_in_handler", exc_busy, 0);

        // Exception return
        eret = 1'b1;
        tick();
        eret = 1'b0;
        @(negedge clk);
        chk("ret_sel", pc_sel, 3);
        chk("ret_if_flush", if_flush, 1);
        chk("ret_busy", exc_busy, 1);
        tick();
        @(negedge clk);
        chk("ret_run_sel", pc_sel, 0);
        chk("ret_run_busy", exc_busy, 0);

        // eret in RUN is a no-op
        eret = 1'b1;
        tick();
        eret = 1'b0;
        @(negedge clk);
        chk("eret_run_busy", exc_busy, 0);
        chk("eret_run_sel", pc_sel, 0);
        tick();

`ifdef PIPE_CTRL_IRQ_EN
        // Interrupt held through the handler: one ack, then a new one after eret
        irq_req = 1'b1; irq_vector = 5'h03;
        @(negedge clk);
        chk("irq_epc_write", epc_write, 1);
        tick();
        @(negedge clk);
        chk("irq_ack1", irq_ack, 1);
        chk("irq_vector", vector_out, 5'h03);
        tick();
        @(negedge clk);
        chk("irq_ack2", irq_ack, 0);
        tick();
        tick();
        repeat (3) begin
            @(negedge clk);
            chk("irq_hdl_noack", irq_ack, 0);
            chk("irq_hdl_busy", exc_busy, 0);
            tick();
        end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        @(negedge clk);
        chk("irq_ret_sel", pc_sel, 3);
        chk("irq_ret_ack", irq_ack, 0);
        tick();
        @(negedge clk);
        chk("irq_retake_epc", epc_write, 1);
        tick();
        irq_req = 1'b0;
        @(negedge clk);
        chk("irq_reack", irq_ack, 1);
        finish_event();

        // Exception beats interrupt
        exc_valid = 1'b1; exc_code = 5'h0A; irq_req = 1'b1; irq_vector = 5'h04;
        tick();
        exc_valid = 1'b0; irq_req = 1'b0;
        @(negedge clk);
        chk("prio_vector", vector_out, 5'h0A);
        chk("prio_ack", irq_ack, 0);
        finish_event();
`else
        // Interrupt path absent: request has no effect
        irq_req = 1'b1; irq_vector = 5'h03;
        @(negedge clk);
        chk("noirq_pc_write", pc_write, 1);
        chk("noirq_busy", exc_busy, 0);
        tick();
        @(negedge clk);
        chk("noirq_ack", irq_ack, 0);
        chk("noirq_vector", vector_out, 5'h1F);
        tick();
        irq_req = 1'b0;
`endif

        // Asynchronous reset in the middle of the drain
`ifdef PIPE_CTRL_IRQ_EN
        irq_req = 1'b1; irq_vector = 5'h09;
        tick();
        irq_req = 1'b0;
        chk("pre_rst_ack", irq_ack, 1);
`else
        exc_valid = 1'b1; exc_code = 5'h11;
        tick();
        exc_valid = 1'b0;
        chk("pre_rst_busy", exc_busy, 1);
`endif
        reset = 1'b0;
        #1;
        chk("rst_mid_busy", exc_busy, 0);
        chk("rst_mid_ack", irq_ack, 0);
        chk("rst_mid_vector", vector_out, 0);
        chk("rst_mid_pc_write", pc_write, 1);
        chk("rst_mid_ex_flush", ex_flush, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("post_rst_busy", exc_busy, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage core. It drives the write and flush controls of the IF/ID register (`if_id_write`, `if_flush`), the exception vector code into `vector_if`, the PC write enable and the PC source select. It detects load-use hazards, flushes on taken branches, and sequences precise exceptions, external interrupts and exception return through a small state machine with a configurable drain counter.

## Interface
- `DRAIN_CYCLES`, default 2: flush cycles between exception acceptance and vector redirect; legal range 1..15.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `id_ex_mem_read`  in  1  instruction in EX is a load.
- `id_ex_rt`  in  5  load destination register in EX.
- `if_id_rs`, `if_id_rt`  in  5 each  source registers of the instruction in ID.
- `branch_taken`  in  1  branch/jump resolved taken in ID.
- `exc_valid`  in  1  EX-stage exception (overflow, illegal op).
- `exc_code`  in  5  cause code qualifying `exc_valid`.
- `irq_req`  in  1  external interrupt request, level; held until acked.
- `irq_vector`  in  5  interrupt cause code.
- `eret`  in  1  return-from-exception decoded in ID.
- `pc_write`  out  1  PC register enable.
- `pc_sel`  out  2  PC source: 00 pc+4, 01 branch target, 10 vector base, 11 EPC.
- `if_id_write`  out  1  IF/ID hold when 0.
- `if_flush`  out  1  zero IF/ID.
- `id_flush`  out  1  bubble into ID/EX.
- `ex_flush`  out  1  bubble into EX/MEM.
- `epc_write`  out  1  capture faulting PC into EPC.
- `vector_out`  out  5  registered cause code, feeds `vector_if_in`.
- `irq_ack`  out  1  one-cycle registered acknowledge.
- `exc_busy`  out  1  high in any state other than RUN and HANDLER.

## Operation
- States: RUN, FLUSH, VECTOR, HANDLER, RETURN. Reset enters RUN, with `vector_out`=0, `irq_ack`=0, drain counter=0 and IRQ mask=0.
- Defaults (RUN/HANDLER, no event): `pc_write`=1, `if_id_write`=1, `pc_sel`=00, all flushes=0, `epc_write`=0.
- Priority within RUN/HANDLER: exception > interrupt > load-use stall > branch.
- Exception (`exc_valid`=1, in RUN or HANDLER):
  - Same cycle, combinationally: `if_flush`=`id_flush`=`ex_flush`=1 and `pc_write`=0.
  - In RUN: `epc_write`=1 and `vector_out`<=`exc_code`.
  - In HANDLER (double fault): `epc_write`=0 and `vector_out`<=5'h1F.
  - Next state FLUSH; counter<=`DRAIN_CYCLES`.
- Interrupt (`irq_req`=1, RUN only, mask=0):
  - Same flush/`epc_write` behaviour as an exception.
  - `vector_out`<=`irq_vector`; `irq_ack` pulses the following cycle.
  - Next state FLUSH. Interrupts are ignored in HANDLER.
- FLUSH: `if_flush`=`id_flush`=`ex_flush`=1 and `pc_write`=0. Counter decrements each cycle; at 1 go to VECTOR.
- VECTOR (1 cycle): `pc_sel`=10, `pc_write`=1, `if_flush`=1; set mask; next state HANDLER.
- Load-use stall: `id_ex_mem_read` && `id_ex_rt`!=0 && (`id_ex_rt`==`if_id_rs` || `id_ex_rt`==`if_id_rt`).
  - Drives `pc_write`=0, `if_id_write`=0, `id_flush`=1.
  - Any `branch_taken` in the same cycle is ignored; it is re-evaluated after the stall.
- Branch (no stall): `pc_sel`=01, `if_flush`=1.
- `eret` in HANDLER (no stall, no exception): go to RETURN.
- RETURN (1 cycle): `pc_sel`=11, `pc_write`=1, `if_flush`=1; clear mask; next state RUN.
- `eret` in RUN is treated as a no-op.

## Timing
- Exception or interrupt sampled at edge N: FLUSH occupies cycles N+1 .. N+`DRAIN_CYCLES`, VECTOR is cycle N+`DRAIN_CYCLES`+1, HANDLER begins at N+`DRAIN_CYCLES`+2.
- `vector_out` is valid from cycle N+1 and holds until the next accepted event.
- `irq_ack` is high in cycle N+1 only.
- Stall and branch controls are combinational, with zero-cycle latency.
- `reset` low at any time forces RUN asynchronously and clears the mask and counter. A pending `irq_ack` is dropped.
- `exc_valid` and `irq_req` in FLUSH, VECTOR or RETURN are ignored. The source must hold them: `irq_req` is level, and EX re-raises the exception after the flush.

## Configuration
- `PIPE_CTRL_IRQ_EN` defined: interrupt path, IRQ mask and `irq_ack` are present as described.
- `PIPE_CTRL_IRQ_EN` undefined: `irq_req`/`irq_vector` are ignored, `irq_ack` is tied 0 and the mask logic is removed. Exceptions, stalls, branches and `eret` are unchanged.

## Test plan
- Load-use: `id_ex_mem_read`=1, `id_ex_rt`=5, `if_id_rs`=5 -> one cycle with `pc_write`=0, `if_id_write`=0, `id_flush`=1. Same stimulus with `id_ex_rt`=0 -> no stall.
- Stall plus `branch_taken` in the same cycle -> `pc_sel`=00 and `if_flush`=0. Next cycle (no stall) -> `pc_sel`=01, `if_flush`=1.
- `exc_valid`=1, `exc_code`=5'h0C in RUN at edge N (`DRAIN_CYCLES`=2) -> `epc_write`=1 at N, `vector_out`=5'h0C at N+1, flushes during N+1..N+2, `pc_sel`=10 at N+3, `exc_busy` low from N+4.
- `irq_req`=1, `irq_vector`=5'h03 in RUN -> `irq_ack` high for exactly 1 cycle; `irq_req` held in HANDLER -> no second ack; `eret` -> `pc_sel`=11 for 1 cycle, then a new ack.
- `exc_valid` in HANDLER -> `vector_out`=5'h1F and `epc_write`=0.
- `reset` low mid-FLUSH -> all state cleared immediately, defaults restored; `irq_ack`=0.
